// File: rtl/vga_frame_ctrl_if.sv
// Framebuffer update handshake between game logic (master) and the
// VGA frame controller (slave).
interface vga_frame_ctrl_if;
    logic upd_req;
    logic upd_grant;
    logic upd_done;
    logic upd_overrun;

    modport master (
        output upd_req,
        output upd_done,
        input  upd_grant,
        input  upd_overrun
    );

    modport slave (
        input  upd_req,
        input  upd_done,
        output upd_grant,
        output upd_overrun
    );
endinterface

// File: rtl/vga_frame_ctrl.sv
// VGA raster timing with a vblank-only framebuffer update arbiter.
// Sync/video decodes are combinational off the counter registers.
module vga_frame_ctrl #(
    parameter int H_TOTAL      = 800,
    parameter int H_VISIBLE    = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 752,
    parameter int V_TOTAL      = 525,
    parameter int V_VISIBLE    = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 492
) (
    input  logic             clk,
    input  logic             rst,
    vga_frame_ctrl_if.slave  upd,
    output logic [9:0]       h_count,
    output logic [9:0]       v_count,
    output logic             v_enable,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
    localparam logic [9:0] H_SE   = 10'(H_SYNC_END);
    localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
    localparam logic [9:0] V_SE   = 10'(V_SYNC_END);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLANK,
        GRANT,
        RELEASE
    } state_t;

    logic [9:0] r_h;
    logic [9:0] r_v;
    state_t     r_state;
    logic       r_grant;
    logic       r_overrun;

    logic       w_h_last;
    logic       w_v_last;
    logic       w_vblank;
    logic       w_frame_end;

    assign w_h_last    = (r_h == H_LAST);
    assign w_v_last    = (r_v == V_LAST);
    assign w_vblank    = (r_v >= V_VIS);
    assign w_frame_end = w_h_last && w_v_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
        end else begin
            r_h <= r_h + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
        end else if (w_h_last) begin
            r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
        end
    end

    // A grant never opens on frame_end: the window would close that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (upd.upd_req) begin
                        r_state <= WAIT_BLANK;
                    end
                end
                WAIT_BLANK: begin
                    if (!upd.upd_req) begin
                        r_state <= IDLE;
                    end else if (w_vblank && !w_frame_end) begin
                        r_state <= GRANT;
                        r_grant <= 1'b1;
                    end
                end
                GRANT: begin
                    if (upd.upd_done) begin
                        r_state <= RELEASE;
                        r_grant <= 1'b0;
                    end else if (w_frame_end) begin
                        r_state   <= WAIT_BLANK;
                        r_grant   <= 1'b0;
                        r_overrun <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (!upd.upd_req) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 1'b0;
                end
            endcase
        end
    end

    assign h_count         = r_h;
    assign v_count         = r_v;
    assign v_enable        = w_h_last;
    assign hsync           = !((r_h >= H_SS) && (r_h < H_SE));
    assign vsync           = !((r_v >= V_SS) && (r_v < V_SE));
    assign video_on        = (r_h < H_VIS) && (r_v < V_VIS);
    assign upd.upd_grant   = r_grant;
    assign upd.upd_overrun = r_overrun;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Scoreboarded bench: a reduced-size raster for frame-level scenarios
// plus a default-parameter instance for the 640x480 line timing.
module tb_vga_frame_ctrl;

    localparam int HT  = 40;
    localparam int HV  = 32;
    localparam int HSS = 33;
    localparam int HSE = 37;
    localparam int VT  = 25;
    localparam int VV  = 20;
    localparam int VSS = 21;
    localparam int VSE = 23;

    localparam int S_IDLE  = 0;
    localparam int S_WAIT  = 1;
    localparam int S_GRANT = 2;
    localparam int S_REL   = 3;

    typedef struct {
        int h;
        int v;
        int st;
        bit gr;
        bit ov;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       v_enable;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] dh;
    logic [9:0] dv;
    logic       dven;
    logic       dhs;
    logic       dvs;
    logic       dvon;

    vga_frame_ctrl_if ifs ();
    vga_frame_ctrl_if ifd ();

    vga_frame_ctrl #(
        .H_TOTAL     (HT),
        .H_VISIBLE   (HV),
        .H_SYNC_START(HSS),
        .H_SYNC_END  (HSE),
        .V_TOTAL     (VT),
        .V_VISIBLE   (VV),
        .V_SYNC_START(VSS),
        .V_SYNC_END  (VSE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .upd     (ifs.slave),
        .h_count (h_count),
        .v_count (v_count),
        .v_enable(v_enable),
        .hsync   (hsync),
        .vsync   (vsync),
        .video_on(video_on)
    );

    vga_frame_ctrl dut_d (
        .clk     (clk),
        .rst     (rst),
        .upd     (ifd.slave),
        .h_count (dh),
        .v_count (dv),
        .v_enable(dven),
        .hsync   (dhs),
        .vsync   (dvs),
        .video_on(dvon)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    mdl_t m;
    mdl_t sb[$];

    function automatic mdl_t mreset();
        mdl_t r;
        r.h  = 0;
        r.v  = 0;
        r.st = S_IDLE;
        r.gr = 1'b0;
        r.ov = 1'b0;
        return r;
    endfunction

    function automatic mdl_t step(mdl_t c, bit req, bit done);
        mdl_t n;
        bit   fe;
        bit   vb;
        n  = c;
        fe = (c.h == HT - 1) && (c.v == VT - 1);
        vb = (c.v >= VV);
        n.h = (c.h + 1) % HT;
        if (c.h == HT - 1) n.v = (c.v + 1) % VT;
        case (c.st)
            S_IDLE:  if (req) n.st = S_WAIT;
            S_WAIT:  if (!req) n.st = S_IDLE;
                     else if (vb && !fe) n.st = S_GRANT;
            S_GRANT: if (done) n.st = S_REL;
                     else if (fe) begin
                         n.st = S_WAIT;
                         n.ov = 1'b1;
                     end
            default: if (!req) n.st = S_IDLE;
        endcase
        n.gr = (n.st == S_GRANT);
        return n;
    endfunction

    // Push the expectation for the coming edge, compare once it has happened.
    task automatic tick();
        mdl_t       e;
        logic [9:0] a[8];
        logic [9:0] x[8];
        string      nm[8];
        e = rst ? mreset() : step(m, ifs.upd_req, ifs.upd_done);
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        m = e;
        nm = '{"h_count", "v_count", "v_enable", "hsync",
               "vsync", "video_on", "upd_grant", "upd_overrun"};
        a = '{h_count, v_count, 10'(v_enable), 10'(hsync),
              10'(vsync), 10'(video_on), 10'(ifs.upd_grant),
              10'(ifs.upd_overrun)};
        x[0] = 10'(e.h);
        x[1] = 10'(e.v);
        x[2] = 10'(e.h == HT - 1);
        x[3] = 10'(!(e.h >= HSS && e.h < HSE));
        x[4] = 10'(!(e.v >= VSS && e.v < VSE));
        x[5] = 10'(e.h < HV && e.v < VV);
        x[6] = 10'(e.gr);
        x[7] = 10'(e.ov);
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (a[i] !== x[i]) begin
                n_fail++;
                $display("FAIL sb_%s at t=%0t: got %0d expected %0d",
                         nm[i], $time, a[i], x[i]);
            end
        end
    endtask

    task automatic run_to(int h, int v);
        int k;
        k = 0;
        while (!(m.h == h && m.v == v) && k < 3 * HT * VT) begin
            tick();
            k++;
        end
        n_chk++;
        if (!(m.h == h && m.v == v)) begin
            n_fail++;
            $display("FAIL run_to: stuck at h=%0d v=%0d, wanted h=%0d v=%0d",
                     m.h, m.v, h, v);
        end
    endtask

    task automatic wait_grant();
        int k;
        k = 0;
        while (ifs.upd_grant !== 1'b1 && k < 2 * HT * VT) begin
            tick();
            k++;
        end
        n_chk++;
        if (ifs.upd_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_grant: got grant=%b after %0d cycles, required 1",
                     ifs.upd_grant, k);
        end
    endtask

    task automatic test_reset();
        m = mreset();
        @(negedge clk);
        tick();
        n_chk++;
        if ({h_count, v_count, v_enable, hsync, vsync, video_on,
             ifs.upd_grant, ifs.upd_overrun} !== {20'd0, 6'b011100}) begin
            n_fail++;
            $display("FAIL reset_hold: h=%0d v=%0d ven=%b hs=%b vs=%b von=%b gr=%b ov=%b",
                     h_count, v_count, v_enable, hsync, vsync, video_on,
                     ifs.upd_grant, ifs.upd_overrun);
        end
        rst = 1'b0;
        tick();
        n_chk++;
        if (h_count !== 10'd1 || v_count !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_first_edge: h=%0d v=%0d, required h=1 v=0",
                     h_count, v_count);
        end
        run_to(30, 12);
        #1 rst = 1'b1;
        m = mreset();
        #1;
        n_chk++;
        if ({h_count, v_count, v_enable, hsync, vsync, video_on,
             ifs.upd_grant, ifs.upd_overrun} !== {20'd0, 6'b011100}) begin
            n_fail++;
            $display("FAIL reset_async: h=%0d v=%0d ven=%b hs=%b vs=%b von=%b gr=%b ov=%b",
                     h_count, v_count, v_enable, hsync, vsync, video_on,
                     ifs.upd_grant, ifs.upd_overrun);
        end
        tick();
        rst = 1'b0;
        tick();
        n_chk++;
        if (h_count !== 10'd1 || v_count !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_restart: h=%0d v=%0d, required h=1 v=0",
                     h_count, v_count);
        end
    endtask

    task automatic test_defaults();
        int k;
        int lows;
        int first;
        int von;
        int ven;
        int venh;
        k = 0;
        while (dh !== 10'd799 && k < 1000) begin
            tick();
            k++;
        end
        n_chk++;
        if (dh !== 10'd799 || dv !== 10'd0) begin
            n_fail++;
            $display("FAIL def_line0_end: h=%0d v=%0d, required h=799 v=0", dh, dv);
        end
        lows  = 0;
        first = -1;
        von   = 0;
        ven   = 0;
        venh  = -1;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (!dhs) begin
                lows++;
                if (first < 0) first = int'(dh);
            end
            if (dvon) von++;
            if (dven) begin
                ven++;
                venh = int'(dh);
            end
        end
        n_chk++;
        if (lows != 96 || first != 656) begin
            n_fail++;
            $display("FAIL def_hsync: %0d low from h=%0d, required 96 from h=656",
                     lows, first);
        end
        n_chk++;
        if (von != 640) begin
            n_fail++;
            $display("FAIL def_video_on: %0d clocks, required 640", von);
        end
        n_chk++;
        if (ven != 1 || venh != 799) begin
            n_fail++;
            $display("FAIL def_v_enable: %0d pulses at h=%0d, required 1 at h=799",
                     ven, venh);
        end
        n_chk++;
        if (dh !== 10'd799 || dv !== 10'd1) begin
            n_fail++;
            $display("FAIL def_line1_end: h=%0d v=%0d, required h=799 v=1", dh, dv);
        end
    endtask

    task automatic test_wrap();
        run_to(HT - 2, 10);
        tick();
        n_chk++;
        if (h_count !== 10'(HT - 1) || v_count !== 10'd10 || v_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_last_pixel: h=%0d v=%0d ven=%b, required h=%0d v=10 ven=1",
                     h_count, v_count, v_enable, HT - 1);
        end
        tick();
        n_chk++;
        if (h_count !== 10'd0 || v_count !== 10'd11 || v_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_line: h=%0d v=%0d ven=%b, required h=0 v=11 ven=0",
                     h_count, v_count, v_enable);
        end
        run_to(HT - 1, VT - 1);
        tick();
        n_chk++;
        if (h_count !== 10'd0 || v_count !== 10'd0) begin
            n_fail++;
            $display("FAIL wrap_frame: h=%0d v=%0d, required h=0 v=0",
                     h_count, v_count);
        end
    endtask

    task automatic test_frame();
        int  lows;
        int  runs;
        bit  prev;
        int  vlow;
        int  vmin;
        int  vmax;
        int  von;
        run_to(HT - 1, VT - 1);
        lows = 0;
        runs = 0;
        prev = 1'b1;
        vlow = 0;
        vmin = -1;
        vmax = -1;
        von  = 0;
        for (int i = 0; i < HT * VT; i++) begin
            tick();
            if (!hsync) lows++;
            if (!hsync && prev) runs++;
            prev = hsync;
            if (!vsync) begin
                vlow++;
                if (vmin < 0) vmin = int'(v_count);
                vmax = int'(v_count);
            end
            if (video_on) von++;
            if (h_count == 10'(HT - 1)) begin
                n_chk++;
                if (lows != HSE - HSS || runs != 1) begin
                    n_fail++;
                    $display("FAIL frame_hsync v=%0d: %0d low in %0d runs, required %0d in 1",
                             v_count, lows, runs, HSE - HSS);
                end
                lows = 0;
                runs = 0;
            end
        end
        n_chk++;
        if (vlow != (VSE - VSS) * HT || vmin != VSS || vmax != VSE - 1) begin
            n_fail++;
            $display("FAIL frame_vsync: %0d clocks lines %0d..%0d, required %0d lines %0d..%0d",
                     vlow, vmin, vmax, (VSE - VSS) * HT, VSS, VSE - 1);
        end
        n_chk++;
        if (von != HV * VV) begin
            n_fail++;
            $display("FAIL frame_video_on: %0d clocks, required %0d", von, HV * VV);
        end
    endtask

    task automatic test_grant();
        int g;
        run_to(0, 5);
        ifs.upd_req = 1'b1;
        wait_grant();
        n_chk++;
        if (h_count !== 10'd1 || v_count !== 10'(VV)) begin
            n_fail++;
            $display("FAIL grant_start: first grant at h=%0d v=%0d, required h=1 v=%0d",
                     h_count, v_count, VV);
        end
        run_to(0, VV + 2);
        n_chk++;
        if (ifs.upd_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL grant_held: grant=%b, required 1", ifs.upd_grant);
        end
        ifs.upd_done = 1'b1;
        tick();
        ifs.upd_done = 1'b0;
        n_chk++;
        if (ifs.upd_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL grant_done: grant=%b, required 0", ifs.upd_grant);
        end
        g = 0;
        for (int i = 0; i < HT * VT + HT; i++) begin
            tick();
            if (ifs.upd_grant) g++;
        end
        n_chk++;
        if (g != 0) begin
            n_fail++;
            $display("FAIL grant_once: %0d grant cycles with req held, required 0", g);
        end
        ifs.upd_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_overrun();
        ifs.upd_req = 1'b1;
        wait_grant();
        run_to(HT - 1, VT - 1);
        n_chk++;
        if (ifs.upd_grant !== 1'b1 || ifs.upd_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_before: grant=%b ovr=%b, required 1 0",
                     ifs.upd_grant, ifs.upd_overrun);
        end
        tick();
        n_chk++;
        if (ifs.upd_grant !== 1'b0 || ifs.upd_overrun !== 1'b1 ||
            h_count !== 10'd0 || v_count !== 10'd0) begin
            n_fail++;
            $display("FAIL ovr_revoke: grant=%b ovr=%b h=%0d v=%0d, required 0 1 0 0",
                     ifs.upd_grant, ifs.upd_overrun, h_count, v_count);
        end
        wait_grant();
        n_chk++;
        if (v_count !== 10'(VV) || h_count !== 10'd1 || ifs.upd_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_regrant: h=%0d v=%0d ovr=%b, required h=1 v=%0d ovr=1",
                     h_count, v_count, ifs.upd_overrun, VV);
        end
        #1 rst = 1'b1;
        m = mreset();
        #1;
        n_chk++;
        if (ifs.upd_grant !== 1'b0 || ifs.upd_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_async_rst: grant=%b ovr=%b, required 0 0",
                     ifs.upd_grant, ifs.upd_overrun);
        end
        tick();
        rst = 1'b0;
        ifs.upd_req = 1'b0;
        tick();
        n_chk++;
        if (h_count !== 10'd1 || v_count !== 10'd0 || ifs.upd_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_restart: h=%0d v=%0d grant=%b, required 1 0 0",
                     h_count, v_count, ifs.upd_grant);
        end
    endtask

    task automatic test_done_at_frame_end();
        int g;
        ifs.upd_req = 1'b1;
        wait_grant();
        run_to(HT - 1, VT - 1);
        ifs.upd_done = 1'b1;
        tick();
        ifs.upd_done = 1'b0;
        n_chk++;
        if (ifs.upd_grant !== 1'b0 || ifs.upd_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL done_fe: grant=%b ovr=%b, required 0 0",
                     ifs.upd_grant, ifs.upd_overrun);
        end
        g = 0;
        for (int i = 0; i < HT * VT; i++) begin
            tick();
            if (ifs.upd_grant) g++;
        end
        n_chk++;
        if (g != 0 || ifs.upd_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL done_fe_release: %0d grant cycles ovr=%b, required 0 0",
                     g, ifs.upd_overrun);
        end
        ifs.upd_req = 1'b0;
        tick();
    endtask

    initial begin
        ifs.upd_req  = 1'b0;
        ifs.upd_done = 1'b0;
        ifd.upd_req  = 1'b0;
        ifd.upd_done = 1'b0;
        test_reset();
        test_defaults();
        test_wrap();
        test_frame();
        test_grant();
        test_overrun();
        test_done_at_frame_end();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
